// File: rtl/ghost_dir_ctrl.sv
// Per-frame direction scheduler and behaviour-mode timer for one ghost.
// Chooses one legal direction per frame toward a mode-dependent target, reversing only on mode changes.
module ghost_dir_ctrl #(
    parameter int         SCATTER_FRAMES = 210,
    parameter int         CHASE_FRAMES   = 600,
    parameter int         FRIGHT_FRAMES  = 180,
    parameter int         SCATTER_X      = 600,
    parameter int         SCATTER_Y      = 10,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic [10:0] ghostX,
    input  logic [10:0] ghostY,
    input  logic [10:0] pacmanX,
    input  logic [10:0] pacmanY,
    input  logic        powerPellet,
    output logic [1:0]  direction,
    output logic [1:0]  mode,
    output logic        frightened
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCATTER = 2'd1, CHASE = 2'd2, FRIGHT = 2'd3} mode_t;

    localparam int MAX_SC     = (SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES;
    localparam int MAX_FRAMES = (MAX_SC > FRIGHT_FRAMES) ? MAX_SC : FRIGHT_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);

    mode_t              state, next_state;
    logic [CW-1:0]      count, next_count;
    logic [7:0]         lfsr;
    logic               blocked, changed;
    logic [1:0]         blocked_dir, next_dir;

    logic [10:0]        tgt_x, tgt_y;
    logic signed [11:0] dx, dy;
    logic [11:0]        adx, ady;
    logic [1:0]         horiz, vert, prim, sec, rev_dir, start, excl_dir;
    logic               excl_valid, decide;

    // Returns the first of six packed candidates (MSB first) that is neither the reverse nor blocked.
    function automatic logic [1:0] first_free(input logic [11:0] cands, input logic [1:0] rev,
                                              input logic bv, input logic [1:0] bd);
        logic [1:0] r;
        logic [1:0] c;
        logic       found;
        r     = cands[11:10];
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c = cands[11 - 2*i -: 2];
            if (!found && c != rev && !(bv && c == bd)) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        next_state = state;
        next_count = count;
        if (powerPellet && state != IDLE) begin
            next_state = FRIGHT;
            next_count = CW'(FRIGHT_FRAMES);
        end else if (startOfFrame) begin
            case (state)
                IDLE: begin
                    next_state = SCATTER;
                    next_count = CW'(SCATTER_FRAMES);
                end
                SCATTER: begin
                    if (count == CW'(1)) begin
                        next_state = CHASE;
                        next_count = CW'(CHASE_FRAMES);
                    end else next_count = count - CW'(1);
                end
                default: begin
                    if (count == CW'(1)) begin
                        next_state = (state == CHASE) ? SCATTER : CHASE;
                        next_count = (state == CHASE) ? CW'(SCATTER_FRAMES) : CW'(CHASE_FRAMES);
                    end else next_count = count - CW'(1);
                end
            endcase
        end
    end

    assign tgt_x = (state == SCATTER) ? 11'(SCATTER_X) : pacmanX;
    assign tgt_y = (state == SCATTER) ? 11'(SCATTER_Y) : pacmanY;
    assign dx    = $signed({tgt_x[10], tgt_x}) - $signed({ghostX[10], ghostX});
    assign dy    = $signed({tgt_y[10], tgt_y}) - $signed({ghostY[10], ghostY});
    assign adx   = dx[11] ? $unsigned(-dx) : $unsigned(dx);
    assign ady   = dy[11] ? $unsigned(-dy) : $unsigned(dy);
    assign horiz = (!dx[11] && dx != 12'sd0) ? 2'd2 : 2'd3;
    assign vert  = (!dy[11] && dy != 12'sd0) ? 2'd1 : 2'd0;
    assign prim  = (adx >= ady) ? horiz : vert;
    assign sec   = (adx >= ady) ? vert : horiz;

    assign rev_dir    = direction ^ 2'b01;
    assign start      = lfsr[1:0];
    // A collision in the decision cycle counts as if it had been latched earlier.
    assign excl_valid = blocked | collision;
    assign excl_dir   = collision ? direction : blocked_dir;
    assign decide     = startOfFrame && state != IDLE;

    always_comb begin
        if (changed || next_state != state)
            next_dir = rev_dir;
        else if (state == FRIGHT)
            next_dir = first_free({start, start + 2'd1, start + 2'd2, start + 2'd3, start, start},
                                  rev_dir, excl_valid, excl_dir);
        else
            next_dir = first_free({prim, sec, 2'd0, 2'd3, 2'd1, 2'd2}, rev_dir, excl_valid, excl_dir);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            count       <= '0;
            lfsr        <= LFSR_SEED;
            direction   <= 2'd3;
            frightened  <= 1'b0;
            blocked     <= 1'b0;
            blocked_dir <= 2'd0;
            changed     <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            state      <= next_state;
            count      <= next_count;
            frightened <= (next_state == FRIGHT);
            if (decide) begin
                direction <= next_dir;
                blocked   <= 1'b0;
                changed   <= 1'b0;
            end else begin
                if (collision) begin
                    blocked     <= 1'b1;
                    blocked_dir <= direction;
                end
                // Entry from IDLE is not a reversal-triggering change.
                if (next_state != state && state != IDLE) changed <= 1'b1;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_ghost_dir_ctrl.sv
// Bench for ghost_dir_ctrl: default-timer instance plus a short-timer instance for the mode cycle.
module tb_ghost_dir_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        collision = 1'b0;
    logic        powerPellet = 1'b0;
    logic [10:0] ghostX = 11'd100;
    logic [10:0] ghostY = 11'd100;
    logic [10:0] pacmanX = 11'd300;
    logic [10:0] pacmanY = 11'd150;
    logic [1:0]  dir_a, mode_a, dir_b, mode_b;
    logic        fr_a, fr_b;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_lfsr;
    logic [7:0]  sof_lfsr;
    logic [1:0]  exp_dir;
    logic        blk_pend = 1'b0;
    logic [1:0]  blk_dir = 2'd0;
    logic [1:0]  exp_q[$];

    typedef struct {
        logic [1:0] mode_b;
        logic [1:0] dir_b;
        logic [1:0] dir_a;
    } t2_vec_t;

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        col_pre;
        logic        col_sof;
        logic [1:0]  dir;
    } chase_vec_t;

    t2_vec_t    t2v[10];
    chase_vec_t cv[11];

    ghost_dir_ctrl dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
        .ghostX(ghostX), .ghostY(ghostY), .pacmanX(pacmanX), .pacmanY(pacmanY),
        .powerPellet(powerPellet), .direction(dir_a), .mode(mode_a), .frightened(fr_a)
    );

    ghost_dir_ctrl #(.SCATTER_FRAMES(3), .CHASE_FRAMES(4)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
        .ghostX(ghostX), .ghostY(ghostY), .pacmanX(pacmanX), .pacmanY(pacmanY),
        .powerPellet(powerPellet), .direction(dir_b), .mode(mode_b), .frightened(fr_b)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!resetN) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic frame(input logic col, input logic pel);
        @(negedge clk);
        startOfFrame = 1'b1;
        collision    = col;
        powerPellet  = pel;
        sof_lfsr     = m_lfsr;
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        powerPellet  = 1'b0;
    endtask

    task automatic pulse_pellet();
        @(negedge clk);
        powerPellet = 1'b1;
        @(negedge clk);
        powerPellet = 1'b0;
    endtask

    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    function automatic logic [1:0] fright_exp(input logic [1:0] s, input logic [1:0] cur,
                                              input logic bv, input logic [1:0] bd);
        logic [1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = s + 2'(i);
            if (d != (cur ^ 2'b01) && !(bv && d == bd)) return d;
        end
        return 2'd0;
    endfunction

    // One FRIGHT-mode frame; the scoreboard holds the expected direction until compared.
    task automatic fright_frame(input logic rev, input logic pel, input string name);
        logic [1:0] e;
        frame(1'b0, pel);
        if (rev) e = exp_dir ^ 2'b01;
        else     e = fright_exp(sof_lfsr[1:0], exp_dir, blk_pend, blk_dir);
        blk_pend = 1'b0;
        exp_dir  = e;
        exp_q.push_back(e);
        check(name, dir_a, exp_q.pop_front());
    endtask

    initial begin
        t2v[0] = '{2'd1, 2'd3, 2'd3};
        t2v[1] = '{2'd1, 2'd0, 2'd0};
        t2v[2] = '{2'd1, 2'd2, 2'd2};
        t2v[3] = '{2'd2, 2'd3, 2'd2};
        t2v[4] = '{2'd2, 2'd1, 2'd2};
        t2v[5] = '{2'd2, 2'd2, 2'd2};
        t2v[6] = '{2'd2, 2'd2, 2'd2};
        t2v[7] = '{2'd1, 2'd3, 2'd2};
        t2v[8] = '{2'd1, 2'd0, 2'd2};
        t2v[9] = '{2'd1, 2'd2, 2'd2};

        cv[0]  = '{11'd300, 11'd50,  1'b0, 1'b0, 2'd0};
        cv[1]  = '{11'd300, 11'd150, 1'b0, 1'b0, 2'd2};
        cv[2]  = '{11'd0,   11'd100, 1'b0, 1'b0, 2'd0};
        cv[3]  = '{11'd300, 11'd150, 1'b0, 1'b0, 2'd2};
        cv[4]  = '{11'd300, 11'd110, 1'b1, 1'b0, 2'd1};
        cv[5]  = '{11'd300, 11'd110, 1'b0, 1'b0, 2'd2};
        cv[6]  = '{11'd300, 11'd110, 1'b0, 1'b1, 2'd1};
        cv[7]  = '{11'd300, 11'd110, 1'b0, 1'b0, 2'd2};
        cv[8]  = '{11'd120, 11'd400, 1'b0, 1'b0, 2'd1};
        cv[9]  = '{11'd120, 11'h738, 1'b0, 1'b0, 2'd2}; // y = -200
        cv[10] = '{11'd100, 11'd100, 1'b0, 1'b0, 2'd0};

        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dir", dir_a, 2'd3);
        check("reset_mode", mode_a, 2'd0);
        check("reset_fright", fr_a, 1'b0);
        resetN = 1'b1;

        pulse_pellet();
        check("idle_pellet_mode", mode_a, 2'd0);
        check("idle_pellet_fright", fr_a, 1'b0);

        // Frames 1..10: short-timer mode cycle and scatter steering.
        for (int i = 0; i < 10; i++) begin
            frame(1'b0, 1'b0);
            check($sformatf("t2_mode_b[%0d]", i + 1), mode_b, t2v[i].mode_b);
            check($sformatf("t2_dir_b[%0d]", i + 1), dir_b, t2v[i].dir_b);
            check($sformatf("t2_dir_a[%0d]", i + 1), dir_a, t2v[i].dir_a);
            check($sformatf("t2_mode_a[%0d]", i + 1), mode_a, 2'd1);
        end

        for (int f = 11; f <= 210; f++) frame(1'b0, 1'b0);
        check("scatter_end_mode", mode_a, 2'd1);
        frame(1'b0, 1'b0);
        check("chase_entry_mode", mode_a, 2'd2);
        check("chase_entry_reverse", dir_a, 2'd3);

        for (int i = 0; i < 11; i++) begin
            pacmanX = cv[i].px;
            pacmanY = cv[i].py;
            if (cv[i].col_pre) pulse_collision();
            frame(cv[i].col_sof, 1'b0);
            check($sformatf("chase_dir[%0d]", i), dir_a, cv[i].dir);
            check($sformatf("chase_mode[%0d]", i), mode_a, 2'd2);
        end

        pulse_pellet();
        check("pellet1_mode", mode_a, 2'd3);
        check("pellet1_fright", fr_a, 1'b1);
        check("pellet1_dir_hold", dir_a, 2'd0);
        exp_dir = 2'd0;
        fright_frame(1'b1, 1'b0, "fright1_reverse");
        for (int f = 2; f <= 100; f++) begin
            if (f == 50) begin
                pulse_collision();
                blk_pend = 1'b1;
                blk_dir  = exp_dir;
            end
            fright_frame(1'b0, 1'b0, $sformatf("fright1_dir[%0d]", f));
        end
        check("fright1_mode_100", mode_a, 2'd3);

        pulse_pellet();
        check("pellet2_mode", mode_a, 2'd3);
        check("pellet2_fright", fr_a, 1'b1);
        for (int f = 1; f <= 179; f++) fright_frame(1'b0, 1'b0, $sformatf("fright2_dir[%0d]", f));
        check("fright2_mode_179", mode_a, 2'd3);
        fright_frame(1'b1, 1'b0, "fright2_exit_reverse");
        check("fright2_exit_mode", mode_a, 2'd2);
        check("fright2_exit_fright", fr_a, 1'b0);

        pulse_pellet();
        check("pellet3_mode", mode_a, 2'd3);
        fright_frame(1'b1, 1'b0, "fright3_reverse");
        for (int f = 2; f <= 179; f++) fright_frame(1'b0, 1'b0, $sformatf("fright3_dir[%0d]", f));
        fright_frame(1'b0, 1'b1, "pellet_expiry_dir");
        check("pellet_expiry_mode", mode_a, 2'd3);
        check("pellet_expiry_fright", fr_a, 1'b1);
        fright_frame(1'b0, 1'b0, "after_restart_dir");
        check("after_restart_mode", mode_a, 2'd3);

        // Mid-frame reset with a collision pending must leave no blocked state behind.
        @(negedge clk);
        collision = 1'b1;
        resetN    = 1'b0;
        @(negedge clk);
        collision = 1'b0;
        @(negedge clk);
        check("rereset_dir", dir_a, 2'd3);
        check("rereset_mode", mode_a, 2'd0);
        check("rereset_fright", fr_a, 1'b0);
        resetN = 1'b1;
        frame(1'b0, 1'b0);
        check("rereset_first_mode", mode_a, 2'd1);
        check("rereset_first_dir", dir_a, 2'd3);
        frame(1'b0, 1'b0);
        check("rereset_second_dir", dir_a, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
